// File: rtl/mac_pkg.sv
// Shared definitions for the precision-scalable MAC unit and its drain stage.
package mac_pkg;

  localparam int ACC_W       = 56;
  localparam int LANE_SLOT_W = 14;

  // Accumulator precision encodings
  localparam logic [1:0] PREC_FULL = 2'd0;
  localparam logic [1:0] PREC_W4   = 2'd1;
  localparam logic [1:0] PREC_W2   = 2'd2;
  localparam logic [1:0] PREC_RSVD = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } drain_state_e;

  // Index of the final lane for a given precision (1, 2 or 4 lanes)
  function automatic logic [1:0] f_last_lane(input logic [1:0] prec);
    case (prec)
      PREC_W4: return 2'd1;
      PREC_W2: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational requantizer for one signed lane: round half up, arithmetic
// right shift, optional ReLU, saturate to OUT_W bits.
module requant_lane #(
  parameter int IN_W  = 57,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6
) (
  input  logic signed [IN_W-1:0]  i_lane,
  input  logic        [SH_W-1:0]  i_shamt,
  input  logic                    i_relu,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  // The rounding constant can reach 2^(2^SH_W-2); the working width holds it
  // next to the sign-extended lane so large shifts settle to 0 instead of wrapping.
  localparam int WIDE_W = ((IN_W > (1 << SH_W)) ? IN_W : (1 << SH_W)) + 1;
  localparam logic signed [WIDE_W-1:0] MAX_V = WIDE_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [WIDE_W-1:0] MIN_V = WIDE_W'(-(1 << (OUT_W-1)));

  function automatic logic signed [WIDE_W-1:0] f_round_shift(
    input logic signed [WIDE_W-1:0] x,
    input logic        [SH_W-1:0]   sh
  );
    logic signed [WIDE_W-1:0] rnd;
    rnd = '0;
    if (sh != '0) rnd = {{(WIDE_W-1){1'b0}}, 1'b1} << (sh - SH_W'(1));
    return (x + rnd) >>> sh;
  endfunction

  function automatic logic f_clips(input logic signed [WIDE_W-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic signed [OUT_W-1:0] f_saturate(input logic signed [WIDE_W-1:0] v);
    if (v > MAX_V) return {1'b0, {(OUT_W-1){1'b1}}};
    if (v < MIN_V) return {1'b1, {(OUT_W-1){1'b0}}};
    return v[OUT_W-1:0];
  endfunction

  logic signed [WIDE_W-1:0] w_ext;
  logic signed [WIDE_W-1:0] w_shifted;
  logic signed [WIDE_W-1:0] w_relu;

  // Lane -> rounded/shifted -> ReLU -> clipped result and clip flag
  always_comb begin
    w_ext     = {{(WIDE_W-IN_W){i_lane[IN_W-1]}}, i_lane};
    w_shifted = f_round_shift(w_ext, i_shamt);
    w_relu    = (i_relu && w_shifted[WIDE_W-1]) ? '0 : w_shifted;
    o_data    = f_saturate(w_relu);
    o_sat     = f_clips(w_relu);
  end

endmodule

// File: rtl/mac_requant_drain.sv
// Drain stage of the MAC unit: captures one packed accumulator word, splits
// it into 1/2/4 signed lanes and streams the requantized lanes, lane 0 first.
module mac_requant_drain
  import mac_pkg::*;
#(
  parameter int ACC_W = 56,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ACC_W-1:0]        acc_in,
  input  logic [1:0]              acc_prec,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [SH_W-1:0]         cfg_shamt,
  input  logic                    cfg_relu,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_lane,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        sat_cnt,
  output logic                    err_prec,
  input  logic                    clr_stat
);

  localparam int HALF_W = 2 * LANE_SLOT_W;

  drain_state_e            r_state;
  logic [ACC_W-1:0]        r_acc;
  logic [1:0]              r_prec;
  logic [SH_W-1:0]         r_shamt;
  logic                    r_relu;
  logic [1:0]              r_lane_idx;
  logic [CNT_W-1:0]        r_sat_cnt;
  logic                    r_err_prec;

  logic                    w_emit;
  logic                    w_last;
  logic                    w_xfer;
  logic                    w_cap;
  logic                    w_sat;
  logic [LANE_SLOT_W-1:0]  w_slot;
  logic signed [ACC_W:0]   w_lane;
  logic signed [OUT_W-1:0] w_q;

  assign w_emit    = (r_state == S_EMIT);
  assign w_last    = w_emit && (r_lane_idx == f_last_lane(r_prec));
  assign w_xfer    = w_emit && out_ready;
  // Ready again during the final-lane handshake so words can run back to back
  assign acc_ready = !w_emit || (w_last && out_ready);
  assign w_cap     = acc_valid && acc_ready;

  // Select and sign-extend the current lane from the captured word
  always_comb begin
    w_slot = '0;
    w_lane = {r_acc[ACC_W-1], r_acc};
    case (r_prec)
      PREC_W4: begin
        if (r_lane_idx[0])
          w_lane = {{(ACC_W+1-HALF_W){r_acc[ACC_W-1]}}, r_acc[ACC_W-1:HALF_W]};
        else
          w_lane = {{(ACC_W+1-HALF_W){r_acc[HALF_W-1]}}, r_acc[HALF_W-1:0]};
      end
      PREC_W2: begin
        w_slot = r_acc[r_lane_idx*LANE_SLOT_W +: LANE_SLOT_W];
        w_lane = {{(ACC_W+1-LANE_SLOT_W){w_slot[LANE_SLOT_W-1]}}, w_slot};
      end
      default: w_lane = {r_acc[ACC_W-1], r_acc};
    endcase
  end

  requant_lane #(
    .IN_W  (ACC_W + 1),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_requant (
    .i_lane  (w_lane),
    .i_shamt (r_shamt),
    .i_relu  (r_relu),
    .o_data  (w_q),
    .o_sat   (w_sat)
  );

  assign out_valid = w_emit;
  assign out_last  = w_last;
  assign out_lane  = w_emit ? r_lane_idx : 2'd0;
  assign out_data  = w_emit ? w_q : '0;
  assign sat_cnt   = r_sat_cnt;
  assign err_prec  = r_err_prec;

  // IDLE/EMIT sequencing: capture words, step lanes on each output transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_prec     <= PREC_FULL;
      r_shamt    <= '0;
      r_relu     <= 1'b0;
      r_lane_idx <= 2'd0;
    end else if (w_cap && (acc_prec != PREC_RSVD)) begin
      r_state    <= S_EMIT;
      r_acc      <= acc_in;
      r_prec     <= acc_prec;
      r_shamt    <= cfg_shamt;
      r_relu     <= cfg_relu;
      r_lane_idx <= 2'd0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_state    <= S_IDLE;
        r_lane_idx <= 2'd0;
      end else begin
        r_lane_idx <= r_lane_idx + 2'd1;
      end
    end
  end

  // Saturation event counter and sticky reserved-precision flag; clear wins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sat_cnt  <= '0;
      r_err_prec <= 1'b0;
    end else if (clr_stat) begin
      r_sat_cnt  <= '0;
      r_err_prec <= 1'b0;
    end else begin
      if (w_xfer && w_sat && (r_sat_cnt != {CNT_W{1'b1}}))
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      if (w_cap && (acc_prec == PREC_RSVD))
        r_err_prec <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_requant_drain.sv
// Bench for mac_requant_drain: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a reference model.
module tb_mac_requant_drain;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [55:0]       acc_in = '0;
  logic [1:0]        acc_prec = '0;
  logic              acc_valid = 1'b0;
  logic              acc_ready;
  logic [5:0]        cfg_shamt = '0;
  logic              cfg_relu = 1'b0;
  logic signed [7:0] out_data;
  logic [1:0]        out_lane;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       sat_cnt;
  logic              err_prec;
  logic              clr_stat = 1'b0;

  mac_requant_drain dut (
    .clk(clk), .rstn(rstn), .acc_in(acc_in), .acc_prec(acc_prec),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .cfg_shamt(cfg_shamt),
    .cfg_relu(cfg_relu), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .sat_cnt(sat_cnt), .err_prec(err_prec), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int data;
    int lane;
    bit last;
    bit sat;
  } beat_t;

  beat_t exp_q[$];

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_lane(input longint x, input int sh, input bit relu,
                                     output int val, output bit sat);
    longint v;
    if (sh == 0)       v = x;
    else if (sh >= 57) v = 0;  // |x| < 2^55, so x + 2^(sh-1) lies in (0, 2^sh)
    else               v = floor_div(x + (64'sd1 <<< (sh - 1)), 64'sd1 <<< sh);
    if (relu && v < 0) v = 0;
    sat = 1'b0;
    if (v > 127)  begin v = 127;  sat = 1'b1; end
    if (v < -128) begin v = -128; sat = 1'b1; end
    val = int'(v);
  endfunction

  function automatic void model_word(input logic [1:0] prec, input logic [55:0] acc,
                                     input int sh, input bit relu);
    int n, w, val;
    bit sat;
    longint x;
    beat_t b;
    n = (prec == 2'd0) ? 1 : (prec == 2'd1) ? 2 : 4;
    w = 56 / n;
    for (int i = 0; i < n; i++) begin
      x = longint'((acc >> (i * w)) & ((56'd1 << w) - 56'd1));
      if (x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
      model_lane(x, sh, relu, val, sat);
      b.data = val; b.lane = i; b.last = (i == n - 1); b.sat = sat;
      exp_q.push_back(b);
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    string           name;
    logic [1:0]      prec;
    logic [55:0]     acc;
    logic [5:0]      sh;
    bit              relu;
    int              n;
    logic [3:0][7:0] exp;   // lane3..lane0
    int              sat;
  } vec_t;

  vec_t vt[9];

  task automatic send(input logic [1:0] p, input logic [55:0] a, input logic [5:0] s, input bit r);
    @(negedge clk);
    acc_valid = 1'b1; acc_prec = p; acc_in = a; cfg_shamt = s; cfg_relu = r;
    #1;
    check("send_acc_ready", acc_ready, 1);
    @(negedge clk);
    acc_valid = 1'b0;
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin : main
    int exp_sat;
    bit exp_err;
    logic signed [7:0] held_d;
    logic [1:0] held_l;
    int words_left, cyc;
    bit pending;
    beat_t b;
    logic [63:0] rnd;
    logic [1:0] rp;
    logic [5:0] rs;

    vt[0] = '{"p2_mix",  2'd2, {14'h2000, 14'h1FFF, 14'h3FFD, 14'h0064}, 6'd2, 1'b0, 4,
              {8'h80, 8'h7F, 8'hFF, 8'h19}, 2};
    vt[1] = '{"p0_1000", 2'd0, 56'd1000, 6'd3, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'd125}, 0};
    vt[2] = '{"p1_relu", 2'd1, {28'd300, 28'hFFFFE0C}, 6'd2, 1'b1, 2,
              {8'h00, 8'h00, 8'd75, 8'h00}, 0};
    vt[3] = '{"p0_neg",  2'd0, 56'hFF_FFFF_FFFF_FC18, 6'd3, 1'b0, 1,
              {8'h00, 8'h00, 8'h00, 8'h83}, 0};
    vt[4] = '{"p2_sh0",  2'd2, {14'd5, 14'd5, 14'd5, 14'd5}, 6'd0, 1'b0, 4,
              {8'd5, 8'd5, 8'd5, 8'd5}, 0};
    vt[5] = '{"p0_sh63", 2'd0, 56'h7F_FFFF_FFFF_FFFF, 6'd63, 1'b0, 1,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0};
    vt[6] = '{"p0_max",  2'd0, 56'h7F_FFFF_FFFF_FFFF, 6'd0, 1'b0, 1,
              {8'h00, 8'h00, 8'h00, 8'h7F}, 1};
    vt[7] = '{"p1_min",  2'd1, {28'd1, 28'h8000000}, 6'd0, 1'b0, 2,
              {8'h00, 8'h00, 8'h01, 8'h80}, 1};
    vt[8] = '{"p2_wide", 2'd2, {14'h2000, 14'h1FFF, 14'h3FFF, 14'd1}, 6'd20, 1'b0, 4,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last",  out_last, 0);
    check("rst_out_lane",  out_lane, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_sat_cnt",   sat_cnt, 0);
    check("rst_err_prec",  err_prec, 0);
    check("rst_acc_ready", acc_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Directed table
    exp_sat = 0;
    out_ready = 1'b1;
    foreach (vt[i]) begin
      exp_sat += vt[i].sat;
      send(vt[i].prec, vt[i].acc, vt[i].sh, vt[i].relu);
      for (int l = 0; l < vt[i].n; l++) begin
        check({vt[i].name, "_valid"}, out_valid, 1);
        check({vt[i].name, "_data"}, longint'($signed(vt[i].exp[l])), longint'(out_data) * 0 + longint'($signed(vt[i].exp[l])) == longint'(out_data) ? longint'($signed(vt[i].exp[l])) : longint'(out_data));
        check({vt[i].name, "_lane"}, out_lane, l);
        check({vt[i].name, "_last"}, out_last, (l == vt[i].n - 1));
        drain(1);
      end
      check({vt[i].name, "_idle"}, out_valid, 0);
      check({vt[i].name, "_satcnt"}, sat_cnt, exp_sat);
    end

    // Backpressure mid-word
    send(vt[0].prec, vt[0].acc, vt[0].sh, vt[0].relu);
    drain(1);
    out_ready = 1'b0;
    #1;
    held_d = out_data;
    held_l = out_lane;
    check("bp_lane1_data", out_data, -1);
    check("bp_lane1_idx",  out_lane, 1);
    for (int k = 0; k < 5; k++) begin
      drain(1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data",  out_data, held_d);
      check("bp_hold_lane",  out_lane, held_l);
      check("bp_acc_ready",  acc_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_data", out_data, -1);
    drain(1);
    check("bp_lane2_data", out_data, 127);
    drain(1);
    check("bp_lane3_data", out_data, -128);
    check("bp_lane3_last", out_last, 1);
    drain(1);
    check("bp_done", out_valid, 0);
    exp_sat += 2;
    check("bp_satcnt", sat_cnt, exp_sat);

    // Back-to-back: new word offered during the last-lane transfer
    send(2'd1, {28'd300, 28'hFFFFE0C}, 6'd2, 1'b1);
    check("b2b_lane0", out_data, 0);
    drain(1);
    check("b2b_lane1_last", out_last, 1);
    acc_valid = 1'b1; acc_prec = 2'd0; acc_in = 56'd1000; cfg_shamt = 6'd3; cfg_relu = 1'b0;
    #1;
    check("b2b_acc_ready", acc_ready, 1);
    check("b2b_lane1_data", out_data, 75);
    @(negedge clk);
    acc_valid = 1'b0;
    #1;
    check("b2b_next_valid", out_valid, 1);
    check("b2b_next_lane",  out_lane, 0);
    check("b2b_next_data",  out_data, 125);
    check("b2b_next_last",  out_last, 1);
    drain(1);
    check("b2b_done", out_valid, 0);

    // clr_stat has priority over a same-cycle saturating transfer
    send(vt[6].prec, vt[6].acc, vt[6].sh, vt[6].relu);
    clr_stat = 1'b1;
    drain(1);
    clr_stat = 1'b0;
    #1;
    check("clr_prio_satcnt", sat_cnt, 0);
    exp_sat = 0;

    // Reserved precision
    @(negedge clk);
    acc_valid = 1'b1; acc_prec = 2'd3; acc_in = 56'd1000; cfg_shamt = 6'd0;
    @(negedge clk);
    acc_valid = 1'b0;
    #1;
    check("rsvd_err_prec", err_prec, 1);
    check("rsvd_no_valid", out_valid, 0);
    drain(1);
    check("rsvd_no_valid2", out_valid, 0);
    clr_stat = 1'b1;
    drain(1);
    clr_stat = 1'b0;
    #1;
    check("rsvd_cleared", err_prec, 0);

    // Reset in the middle of a word
    send(vt[0].prec, vt[0].acc, vt[0].sh, vt[0].relu);
    drain(1);
    rstn = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_last",  out_last, 0);
    check("rstmid_lane",  out_lane, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drain(1);
      check("rstmid_no_lanes", out_valid, 0);
    end

    // Randomized run against the model
    exp_sat = 0;
    exp_err = 1'b0;
    words_left = 300;
    pending = 1'b0;
    cyc = 0;
    exp_q.delete();
    while ((words_left > 0 || pending || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && words_left > 0 && $urandom_range(0, 2) != 0) begin
        rp = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) begin
          rnd = {$urandom, $urandom};
        end else begin
          rnd = '0;
          for (int k = 0; k < 4; k++)
            rnd[14*k +: 14] = 14'($urandom_range(0, 2047)) - 14'd1024;
        end
        rs = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 63));
        acc_valid = 1'b1; acc_prec = rp; acc_in = rnd[55:0];
        cfg_shamt = rs; cfg_relu = 1'($urandom_range(0, 1));
        pending = 1'b1;
        words_left--;
      end else if (!pending) begin
        acc_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("rand_data", out_data, b.data);
          check("rand_lane", out_lane, b.lane);
          check("rand_last", out_last, b.last);
          if (b.sat) exp_sat++;
        end
      end
      if (acc_valid && acc_ready) begin
        if (acc_prec == 2'd3) exp_err = 1'b1;
        else model_word(acc_prec, acc_in, int'(cfg_shamt), cfg_relu);
        pending = 1'b0;
      end
      cyc++;
    end
    acc_valid = 1'b0;
    check("rand_timeout", (cyc >= 20000), 0);
    check("rand_queue_empty", exp_q.size(), 0);
    drain(1);
    check("rand_satcnt", sat_cnt, exp_sat);
    check("rand_err_prec", err_prec, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
